period_meter: RTL

- Measures the period of a slow external square wave (e.g. the 5 Hz divided tick) in cycles of the 10 MHz system clock.
- It is the receive-side counterpart of the clock divider: the divider turns clk into a slow signal, and this block turns a slow signal back into a clk-cycle count.
- Used for self-check of divider outputs and for measuring external slow clocks/sensors.
- Publishes each completed period with a one-cycle valid strobe and flags loss of signal.

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/period_meter_sync_edge_det.sv | 33 +++
 rtl/period_meter.sv | 78 +++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encodings and clock-derived default timeout
package period_meter_pkg;

   localparam int CLK_HZ          = 10_000_000;
   localparam int REF_HZ          = 5;
   localparam int DEF_TIMEOUT_CYC = 2 * (CLK_HZ / REF_HZ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with rising-edge detector for async inputs
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_async,
   output logic q_sync,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [SYNC_STAGES:0]   fill_q;

   // Shift the async input through the chain; fill_q marks when the chain and
   // prev_q hold real samples, so an input already high at reset release is
   // not mistaken for a rising edge against the artificial reset zeros.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
         prev_q <= sync_q[SYNC_STAGES-1];
         fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      end

   assign q_sync = sync_q[SYNC_STAGES-1];
   assign rise   = q_sync & ~prev_q & fill_q[SYNC_STAGES];

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the period of a slow square wave in clk cycles
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W       = 23,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             clear,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             timeout,
   output logic             measuring
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_d;
   logic             rise, unused_sync, capture, valid_d, timeout_d, measuring_d;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_async(sig_in),
      .q_sync (unused_sync),
      .rise   (rise)
   );

   // State and interval counter registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   // Next state: clear wins, any edge (re)enters RUN, a full count without an edge stalls
   always_comb begin
      state_d = clear ? ST_IDLE
              : rise  ? ST_RUN
              : (state_q == ST_RUN && cnt_q == CNT_MAX) ? ST_STALL
              : state_q;
      cnt_d   = clear ? '0
              : rise  ? CNT_W'(1)
              : (state_q == ST_RUN && cnt_q != CNT_MAX) ? cnt_q + 1'b1
              : cnt_q;
   end

   // Output next values: only an edge that closes a complete RUN interval publishes
   always_comb begin
      capture     = !clear && rise && state_q == ST_RUN;
      period_d    = capture ? cnt_q : period;
      valid_d     = capture;
      timeout_d   = state_d == ST_STALL;
      measuring_d = state_d == ST_RUN;
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         measuring    <= 1'b0;
      end else begin
         period       <= period_d;
         period_valid <= valid_d;
         timeout      <= timeout_d;
         measuring    <= measuring_d;
      end

endmodule
